// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding,
// bit positions on the full-adder operand bus, and a small helper used to
// build that bus.
package serial_add_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions on the 3-bit bus driven into the external full adder.
    localparam int FA_A  = 2;
    localparam int FA_B  = 1;
    localparam int FA_CY = 0;

    // Packs one operand bit pair plus the running carry into full-adder order.
    function automatic logic [2:0] fa_pack(input logic a_bit,
                                           input logic b_bit,
                                           input logic cy_bit);
        logic [2:0] v;
        v        = 3'b000;
        v[FA_A]  = a_bit;
        v[FA_B]  = b_bit;
        v[FA_CY] = cy_bit;
        return v;
    endfunction

endpackage

// File: rtl/serial_add_shreg.sv
// Parameterised right-shift register with parallel load. Load has priority
// over shift; with neither asserted the contents hold. The serial input is
// only looked at while shifting, so an undriven/X serial input is harmless
// when the register is idle.
module serial_add_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             shift_in_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-value select: load, shift right (new bit enters at the MSB), or hold.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (shift_i) begin
            q_d = {shift_in_i, q_q[WIDTH-1:1]};
        end
    end

    // Register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Feeds one operand bit pair plus the stored
// carry per cycle to an external 3-input full adder and assembles the
// WIDTH-bit result LSB first from the returned sum bits.
//
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input: when set on an
// accepted start, B is inverted and the carry seeded with 1 so the result is
// a - b modulo 2^WIDTH (cout = 1 means no borrow). Without the macro the
// block is addition only.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; fa_in parked at 0
//   RUN     | one bit per cycle through the full adder, WIDTH cycles
//   DONE    | one cycle: done pulse, sum/cout freshly updated
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [2:0]       fa_in,
    input  logic             fa_s,
    input  logic             fa_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;

    logic             accept;
    logic             running;
    logic [WIDTH-1:0] b_load_d;
    logic             carry_load_d;
    logic [WIDTH-1:0] sum_final;

    // Only the LSBs of the operand shifters and the upper bits of the result
    // shifter are consumed; the rest of each register is just pipeline depth.
    logic             unused_sh_bits;

    assign accept  = (state_q == ST_IDLE) && start;
    assign running = (state_q == ST_RUN);

    // Operand B and the seed carry as captured on start; subtraction is
    // two's-complement addition of ~b with a forced carry-in.
    always_comb begin
        b_load_d     = b;
        carry_load_d = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load_d     = ~b;
            carry_load_d = 1'b1;
        end
`endif
    end

    serial_add_shreg #(.WIDTH(WIDTH)) u_a_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (a),
        .shift_i    (running),
        .shift_in_i (1'b0),
        .q_o        (a_sh)
    );

    serial_add_shreg #(.WIDTH(WIDTH)) u_b_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (b_load_d),
        .shift_i    (running),
        .shift_in_i (1'b0),
        .q_o        (b_sh)
    );

    // Result shifter: cleared on start, collects one sum bit per RUN cycle.
    serial_add_shreg #(.WIDTH(WIDTH)) u_sum_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i ({WIDTH{1'b0}}),
        .shift_i    (running),
        .shift_in_i (fa_s),
        .q_o        (sum_sh)
    );

    // The last sum bit arrives on the same edge that enters DONE, so the
    // published result is taken from the shifter's next value, not its state.
    assign sum_final = {fa_s, sum_sh[WIDTH-1:1]};

    assign unused_sh_bits = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1], sum_sh[0]};

    // Full-adder operand bus: live only in RUN, parked at zero otherwise.
    always_comb begin
        fa_in = 3'b000;
        if (running) begin
            fa_in = fa_pack(a_sh[0], b_sh[0], carry_q);
        end
    end

    // Sequencer with registered status/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        carry_q <= carry_load_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    carry_q <= fa_c;
                    if (cnt_q == CNT_LAST) begin
                        // Counter parks at zero rather than running past the last bit.
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        sum_q   <= sum_final;
                        cout_q  <= fa_c;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    carry_q <= 1'b0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder wired to
// fa_*. A driver issues operations and pushes expected {cout,sum}; a monitor
// pops and compares on every done pulse and checks result stability between.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub   = 1'b0;
`endif
    logic [2:0]   fa_in;
    logic         fa_s;
    logic         fa_c;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int dones  = 0;
    int pushes = 0;

    logic [W:0] exp_q[$];
    logic [W:0] last_res = '0;
    logic [2:0] trace[16];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .fa_in (fa_in),
        .fa_s  (fa_s),
        .fa_c  (fa_c),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // Behavioural full adder beside the controller.
    assign {fa_c, fa_s} = {1'b0, fa_in[2]} + {1'b0, fa_in[1]} + {1'b0, fa_in[0]};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Monitor: scoreboard pop on done, stability check otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res = '0;
        end else if (done) begin
            dones++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=%0h expected=none", {cout, sum});
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    errors++;
                    $display("FAIL scoreboard_result actual=%0h expected=%0h", {cout, sum}, e);
                end
            end
            last_res = {cout, sum};
        end else begin
            checks++;
            if ({cout, sum} !== last_res) begin
                errors++;
                $display("FAIL result_stable actual=%0h expected=%0h", {cout, sum}, last_res);
            end
        end
    end

    // mode: 0 plain, 1 start poked during RUN, 2 reset abort in RUN, 3 fa_in trace kept
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input logic [W:0] expv, input int mode);
        int n;
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            chk("wait_idle_timeout", 32'(busy), 32'd0);
            return;
        end
        a     = ta;
        b     = tb_;
        cin   = tc;
`ifdef SERIAL_ADD_SUB_EN
        sub   = ts;
`else
        if (ts) $display("note: subtract request ignored in add-only build");
`endif
        start = 1'b1;
        if (mode != 2) begin
            exp_q.push_back(expv);
            pushes++;
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) break;
            if (n < 16) trace[n] = fa_in;
            if (mode == 1 && n == 3) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'hFF;
                cin = 1'b1;
            end
            if (mode == 1 && n == 4) start = 1'b0;
            if (mode == 2 && n == 4) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_sum", 32'(sum), 32'd0);
                chk("abort_cout", 32'(cout), 32'd0);
                chk("abort_fa_in", 32'(fa_in), 32'd0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        chk("done_latency", 32'(n), 32'(W));
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("fa_in_in_done", 32'(fa_in), 32'd0);
        if (mode == 3) begin
            chk("fa_in_bit0", 32'(trace[0]), 32'h6);
            for (int k = 1; k < W; k++) chk("fa_in_bitk", 32'(trace[k]), 32'h5);
        end
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("fa_in_idle", 32'(fa_in), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_fa_in", 32'(fa_in), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h25, 1'b0, 1'b0, 9'h07F, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 3);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 9'h001, 0);
        run_op(8'h10, 8'h10, 1'b0, 1'b0, 9'h020, 1);
        repeat (4) @(negedge clk);
        run_op(8'hAA, 8'h55, 1'b0, 1'b0, 9'h000, 2);
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 9'h007, 0);
`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 0);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF, 0);
`endif

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            logic [W:0]   e;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`endif
            if (rs) e = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
            else    e = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_op(ra, rb, rc, rs, e, 0);
        end

        repeat (5) @(negedge clk);
        chk("done_count", 32'(dones), 32'(pushes));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
